// File: rtl/reg_write_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_write_pkg
//  Description : Shared opcode, select-code, state and decode definitions
//                for the register-write scheduler and the control unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_write_pkg;

  // Request opcodes
  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_WR_RT_ALU = 3'd1;
  localparam logic [2:0] OP_WR_RT_MEM = 3'd2;
  localparam logic [2:0] OP_WR_RD_ALU = 3'd3;
  localparam logic [2:0] OP_LINK_RA   = 3'd4;
  localparam logic [2:0] OP_LINK_RD   = 3'd5;
  localparam logic [2:0] OP_PUSH      = 3'd6;
  localparam logic [2:0] OP_POP       = 3'd7;

  // Destination register select
  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_SP = 2'b01;  // reg 29
  localparam logic [1:0] DST_RA = 2'b10;  // reg 31
  localparam logic [1:0] DST_RD = 2'b11;

  // Write-data source select
  localparam logic [1:0] SRC_ALU    = 2'b00;
  localparam logic [1:0] SRC_MEM    = 2'b01;
  localparam logic [1:0] SRC_PC     = 2'b10;
  localparam logic [1:0] SRC_SP_ADJ = 2'b11;

  // Width of the memory-wait timeout counter
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_MEM = 3'd1,
    ST_WRITE    = 3'd2,
    ST_WRITE_SP = 3'd3,
    ST_FIN      = 3'd4
  } state_t;

  // Per-opcode attributes used by the scheduler
  typedef struct packed {
    logic [1:0] dst;        // destination used in the WRITE state
    logic [1:0] src;        // data source used in the WRITE state
    logic       needs_mem;  // wait for memory data before writing
    logic       two_write;  // POP: WRITE followed by a WRITE_SP
    logic       sp_only;    // PUSH: single WRITE_SP, no WRITE
    logic       nop;        // no register write at all
  } decode_t;

endpackage : reg_write_pkg
`default_nettype wire

// File: rtl/reg_write_decode.sv
`default_nettype none
// ============================================================================
//  Module      : reg_write_decode
//  Description : Combinational opcode table: op -> destination, source and
//                sequencing attributes.
//  Ports       : op  - request opcode
//                dec - decoded attributes (decode_t)
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_write_decode
  import reg_write_pkg::*;
(
  input  logic [2:0] op,
  output decode_t    dec
);

  always_comb begin
    dec = '0;
    unique case (op)
      OP_NOP:       dec.nop = 1'b1;
      OP_WR_RT_ALU: begin dec.dst = DST_RT; dec.src = SRC_ALU; end
      OP_WR_RT_MEM: begin dec.dst = DST_RT; dec.src = SRC_MEM; dec.needs_mem = 1'b1; end
      OP_WR_RD_ALU: begin dec.dst = DST_RD; dec.src = SRC_ALU; end
      OP_LINK_RA:   begin dec.dst = DST_RA; dec.src = SRC_PC;  end
      OP_LINK_RD:   begin dec.dst = DST_RD; dec.src = SRC_PC;  end
      OP_PUSH:      begin dec.dst = DST_SP; dec.src = SRC_SP_ADJ; dec.sp_only = 1'b1; end
      OP_POP: begin
        dec.dst       = DST_RT;
        dec.src       = SRC_MEM;
        dec.needs_mem = 1'b1;
        dec.two_write = 1'b1;
      end
      default:      dec = '0;
    endcase
  end

endmodule : reg_write_decode
`default_nettype wire

// File: rtl/reg_write_sched.sv
`default_nettype none
// ============================================================================
//  Module      : reg_write_sched
//  Description : Sequences register-file writes for a request opcode,
//                optionally waiting for memory data (with timeout) and
//                issuing a second SP-adjust write for POP.
//  Ports       : clk, reset             - clock, sync active-high reset
//                req_valid/req_op       - request handshake and opcode
//                req_ready              - high while idle
//                mem_ready              - memory read data valid
//                stall                  - datapath cannot take a write
//                reg_dst_sel/wdata_sel  - destination / data selects
//                sp_inc                 - SP adjust direction (1:+4, 0:-4)
//                reg_write              - register-file write enable
//                done / err             - completion / timeout pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_write_sched
  import reg_write_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [2:0] req_op,
  output logic       req_ready,
  input  logic       mem_ready,
  input  logic       stall,
  output logic [1:0] reg_dst_sel,
  output logic [1:0] wdata_sel,
  output logic       sp_inc,
  output logic       reg_write,
  output logic       done,
  output logic       err
);

  // Counter value seen in the last permitted wait cycle
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [2:0]       op_q,    op_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             err_q,   err_d;

  logic [2:0]       op_sel;
  decode_t          dec;

  // While idle the incoming opcode steers the first transition; afterwards
  // the latched opcode drives the write selects.
  assign op_sel = (state_q == ST_IDLE) ? req_op : op_q;

  reg_write_decode u_decode (
    .op  (op_sel),
    .dec (dec)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    err_d       = 1'b0;
    req_ready   = 1'b0;
    reg_write   = 1'b0;
    reg_dst_sel = DST_RT;
    wdata_sel   = SRC_ALU;
    sp_inc      = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        cnt_d     = '0;
        if (req_valid) begin
          op_d = req_op;
          if (dec.nop)            state_d = ST_FIN;
          else if (dec.needs_mem) state_d = ST_WAIT_MEM;
          else if (dec.sp_only)   state_d = ST_WRITE_SP;
          else                    state_d = ST_WRITE;
        end
      end

      ST_WAIT_MEM: begin
        if (mem_ready) begin
          state_d = ST_WRITE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Abort: err is registered so it pulses in the first idle cycle
          state_d = ST_IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_WRITE: begin
        reg_write   = ~stall;
        reg_dst_sel = dec.dst;
        wdata_sel   = dec.src;
        if (!stall) begin
          if (dec.two_write) begin
            state_d = ST_WRITE_SP;
          end else begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      ST_WRITE_SP: begin
        reg_write   = ~stall;
        reg_dst_sel = DST_SP;
        wdata_sel   = SRC_SP_ADJ;
        sp_inc      = dec.two_write;  // POP increments, PUSH decrements
        if (!stall) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;

endmodule : reg_write_sched
`default_nettype wire

// File: doc/reg_write_sched.md
REG_WRITE_SCHED -- requirements
Module: reg_write_sched

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, setting the maximum cycles spent in WAIT_MEM before abort (range 1..255).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  a register-write request is presented.
REQ-005 SHALL have port req_op  input  3  request opcode: 0 NOP, 1 WR_RT_ALU, 2 WR_RT_MEM, 3 WR_RD_ALU, 4 LINK_RA, 5 LINK_RD, 6 PUSH, 7 POP.
REQ-006 SHALL have port req_ready  output  1  the block accepts a request this cycle.
REQ-007 SHALL have port mem_ready  input  1  memory read data is valid.
REQ-008 SHALL have port stall  input  1  the datapath cannot take a register write this cycle.
REQ-009 SHALL have port reg_dst_sel  output  2  destination select: 00 rt, 01 reg 29, 10 reg 31, 11 rd.
REQ-010 SHALL have port wdata_sel  output  2  write-data select: 00 ALU, 01 MEM, 10 PC, 11 SP_ADJ.
REQ-011 SHALL have port sp_inc  output  1  SP adjust direction: 1 means +4, 0 means -4; valid while wdata_sel=11.
REQ-012 SHALL have port reg_write  output  1  register-file write enable.
REQ-013 SHALL have port done  output  1  one-cycle pulse marking request completion.
REQ-014 SHALL have port err  output  1  one-cycle pulse marking a memory-timeout abort.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_MEM, WRITE, WRITE_SP, FIN.
REQ-016 req_ready SHALL equal 1 exactly when state=IDLE; a request is accepted on a clock edge where req_valid=1 and req_ready=1, and req_op is latched at that edge.
REQ-017 IDLE SHALL move to FIN for NOP; to WAIT_MEM for ops 2 and 7; to WRITE_SP for op 6; to WRITE for all other ops.
REQ-018 WAIT_MEM SHALL move to WRITE on the first edge with mem_ready=1; mem_ready SHALL be ignored in every other state.
REQ-019 WAIT_MEM SHALL count the cycles spent waiting; when the count reaches MEM_TIMEOUT without mem_ready, the FSM SHALL return to IDLE, pulse err for one cycle, and never assert done or reg_write for that request.
REQ-020 In WRITE, reg_write SHALL equal !stall, with dst/src per op: 1 rt/ALU, 2 rt/MEM, 3 rd/ALU, 4 31/PC, 5 rd/PC, 7 rt/MEM.
REQ-021 In WRITE_SP, reg_write SHALL equal !stall, with reg_dst_sel=01 and wdata_sel=11; sp_inc SHALL be 0 for PUSH and 1 for POP.
REQ-022 WRITE and WRITE_SP SHALL hold state while stall=1; exactly one reg_write=1 cycle SHALL occur per state visit.
REQ-023 Leaving WRITE SHALL go to WRITE_SP for POP and to IDLE otherwise; leaving WRITE_SP SHALL go to IDLE.
REQ-024 done SHALL be asserted in the same cycle as the last reg_write=1 of the request; for NOP, done SHALL be asserted in the single FIN cycle, which then moves to IDLE.
REQ-025 Outside WRITE and WRITE_SP, reg_write SHALL be 0; reg_dst_sel, wdata_sel and sp_inc SHALL be 00/00/0.
REQ-026 Latency from acceptance to done, with no stall or memory wait, SHALL be: 1 cycle for non-memory single writes, PUSH and NOP; 2 cycles for WR_RT_MEM; 3 cycles for POP.
REQ-027 Back-to-back requests SHALL be accepted no sooner than the cycle after the FSM returns to IDLE; a request held across busy cycles SHALL NOT be lost or duplicated.

Reset
REQ-028 reset=1 at any edge SHALL force IDLE, clear the timeout counter and latched op, and set all outputs to 0 except req_ready=1 in the following cycle.
REQ-029 Reset asserted mid-request (including between the two POP writes) SHALL abort the request with no further reg_write, done or err.

Structure
REQ-030 Opcode constants, dst/src select codes and the state encoding SHALL live in shared package reg_write_pkg, which is also used by the control unit.
REQ-031 The op to (dst, src, needs_mem, two_write) table MAY be a combinational sub-module reg_write_decode; the timeout counter SHALL be 8 bits wide.

Verification
REQ-032 Case 1: WR_RD_ALU accepted with stall=0 -> next cycle reg_write=1, dst=11, src=00, done=1; req_ready=1 the cycle after.
REQ-033 Case 2: POP with mem_ready at the 3rd WAIT_MEM cycle -> rt/MEM write, then next cycle 29/SP_ADJ write with sp_inc=1; done accompanies the second write only.
REQ-034 Case 3: PUSH with stall=1 for 2 cycles -> reg_write=0 for 2 cycles, then exactly one write with dst=01, src=11, sp_inc=0, done=1.
REQ-035 Case 4: WR_RT_MEM with mem_ready never asserted, MEM_TIMEOUT=4 -> err pulse after 4 wait cycles, no reg_write, FSM in IDLE.
REQ-036 Case 5: reset asserted during the first POP write cycle -> no WRITE_SP write, no done, req_ready=1 after reset.
REQ-037 Case 6: LINK_RA followed immediately by NOP with req_valid held -> one write (31/PC), then NOP accepted once, done pulses twice in total.
